issue_stage_m1: RTL and testbench

ISSUE_STAGE_M1 -- requirements
Module: issue_stage_m1

---
 rtl/issue_stage_m1_pkg.sv | 13 +
 rtl/issue_stage_m1_if.sv | 43 ++++
 rtl/issue_stage_m1_operand_slot.sv | 50 +++++
 rtl/issue_stage_m1.sv | 99 +++++++++
 tb/tb_issue_stage_m1.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/issue_stage_m1_pkg.sv
// Shared types and widths for the operand-collect issue stage.
package m1_pkg;
    localparam int XLEN = 16;
    localparam int RA_W = 4;

    typedef enum logic [1:0] {IDLE, WAIT, READY} issue_state_t;

    typedef struct packed {
        logic [XLEN-1:0] data;
        logic            pending;
        logic [RA_W-1:0] addr;
    } operand_slot_t;
endpackage

// File: rtl/issue_stage_m1_if.sv
// Decode-side input, writeback snoop and execute-side output bundle of the issue stage.
interface issue_stage_m1_if #(
    parameter int XLEN = m1_pkg::XLEN,
    parameter int RA_W = m1_pkg::RA_W
);
    logic            in_valid;
    logic            in_ready;
    logic [3:0]      in_opcode;
    logic [3:0]      in_func4;
    logic [RA_W-1:0] in_rd_addr;
    logic [RA_W-1:0] in_rs1_addr;
    logic [RA_W-1:0] in_rs2_addr;
    logic [XLEN-1:0] in_rs1_data;
    logic [XLEN-1:0] in_rs2_data;
    logic            in_rs1_busy;
    logic            in_rs2_busy;
    logic            wb_en;
    logic [RA_W-1:0] wb_addr;
    logic [XLEN-1:0] wb_data;
    logic            out_valid;
    logic            out_ready;
    logic [3:0]      out_opcode;
    logic [3:0]      out_func4;
    logic [RA_W-1:0] out_rd_addr;
    logic [XLEN-1:0] out_rs1_data;
    logic [XLEN-1:0] out_rs2_data;

    modport slave (
        input  in_valid, in_opcode, in_func4, in_rd_addr, in_rs1_addr, in_rs2_addr,
               in_rs1_data, in_rs2_data, in_rs1_busy, in_rs2_busy,
               wb_en, wb_addr, wb_data, out_ready,
        output in_ready, out_valid, out_opcode, out_func4, out_rd_addr,
               out_rs1_data, out_rs2_data
    );

    modport master (
        output in_valid, in_opcode, in_func4, in_rd_addr, in_rs1_addr, in_rs2_addr,
               in_rs1_data, in_rs2_data, in_rs1_busy, in_rs2_busy,
               wb_en, wb_addr, wb_data, out_ready,
        input  in_ready, out_valid, out_opcode, out_func4, out_rd_addr,
               out_rs1_data, out_rs2_data
    );
endinterface

// File: rtl/issue_stage_m1_operand_slot.sv
// One source operand: capture on accept, pending flag, and writeback snoop while pending.
module operand_slot_m1
    import m1_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            clk_en_i,
    input  logic            flush_i,
    input  logic            load_i,
    input  logic            busy_i,
    input  logic [RA_W-1:0] addr_i,
    input  logic [XLEN-1:0] data_i,
    input  logic            wb_en_i,
    input  logic [RA_W-1:0] wb_addr_i,
    input  logic [XLEN-1:0] wb_data_i,
    output logic [XLEN-1:0] data_o,
    output logic            pending_o,
    output logic            pending_d_o
);
    operand_slot_t slot_q, slot_d;
    logic          hit_in, hit_held;

    always_comb begin
        slot_d   = slot_q;
        // Register 0 is hardwired: it is never pending and never forwarded.
        hit_in   = wb_en_i && (wb_addr_i == addr_i) && (addr_i != '0);
        hit_held = wb_en_i && slot_q.pending && (wb_addr_i == slot_q.addr) && (slot_q.addr != '0);
        if (clk_en_i) begin
            if (flush_i) begin
                slot_d.pending = 1'b0;
            end else if (load_i) begin
                slot_d.addr    = addr_i;
                slot_d.pending = busy_i && !hit_in && (addr_i != '0);
                slot_d.data    = hit_in ? wb_data_i : data_i;
            end else if (hit_held) begin
                slot_d.data    = wb_data_i;
                slot_d.pending = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) slot_q <= '0;
        else     slot_q <= slot_d;
    end

    assign data_o      = slot_q.data;
    assign pending_o   = slot_q.pending;
    assign pending_d_o = slot_d.pending;
endmodule

// File: rtl/issue_stage_m1.sv
// One-entry operand-collect issue buffer: holds a decoded instruction until both
// source operands are resolved, then offers it to execute.
module issue_stage_m1 #(
    parameter int XLEN = m1_pkg::XLEN,
    parameter int RA_W = m1_pkg::RA_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clk_en,
    input  logic             flush,
    issue_stage_m1_if.slave  bus
);
    import m1_pkg::*;

    issue_state_t    state_q, state_d;
    logic [3:0]      opcode_q, opcode_d;
    logic [3:0]      func4_q, func4_d;
    logic [RA_W-1:0] rd_q, rd_d;
    logic            in_ready, out_valid;
    logic            accept, issue, load;
    logic [XLEN-1:0] rs1_data, rs2_data;
    logic            rs1_pend, rs2_pend, rs1_pend_d, rs2_pend_d;

    assign accept = clk_en && bus.in_valid && in_ready;
    assign issue  = clk_en && out_valid && bus.out_ready;
    assign load   = accept && !flush;

    operand_slot_m1 u_rs1 (
        .clk(clk), .rst(rst), .clk_en_i(clk_en), .flush_i(flush), .load_i(load),
        .busy_i(bus.in_rs1_busy), .addr_i(bus.in_rs1_addr), .data_i(bus.in_rs1_data),
        .wb_en_i(bus.wb_en), .wb_addr_i(bus.wb_addr), .wb_data_i(bus.wb_data),
        .data_o(rs1_data), .pending_o(rs1_pend), .pending_d_o(rs1_pend_d)
    );

    operand_slot_m1 u_rs2 (
        .clk(clk), .rst(rst), .clk_en_i(clk_en), .flush_i(flush), .load_i(load),
        .busy_i(bus.in_rs2_busy), .addr_i(bus.in_rs2_addr), .data_i(bus.in_rs2_data),
        .wb_en_i(bus.wb_en), .wb_addr_i(bus.wb_addr), .wb_data_i(bus.wb_data),
        .data_o(rs2_data), .pending_o(rs2_pend), .pending_d_o(rs2_pend_d)
    );

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE:    in_ready = 1'b1;
            READY: begin
                in_ready  = bus.out_ready;
                out_valid = 1'b1;
            end
            default: in_ready = 1'b0;
        endcase
        if (clk_en) begin
            if (flush) begin
                state_d = IDLE;
            end else if (accept) begin
                state_d = (rs1_pend_d || rs2_pend_d) ? WAIT : READY;
            end else if (issue) begin
                state_d = IDLE;
            end else if (state_q == WAIT && !rs1_pend_d && !rs2_pend_d) begin
                state_d = READY;
            end
        end
    end

    always_comb begin
        opcode_d = opcode_q;
        func4_d  = func4_q;
        rd_d     = rd_q;
        if (load) begin
            opcode_d = bus.in_opcode;
            func4_d  = bus.in_func4;
            rd_d     = bus.in_rd_addr;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            opcode_q <= '0;
            func4_q  <= '0;
            rd_q     <= '0;
        end else begin
            state_q  <= state_d;
            opcode_q <= opcode_d;
            func4_q  <= func4_d;
            rd_q     <= rd_d;
        end
    end

    assign bus.in_ready     = in_ready;
    assign bus.out_valid    = out_valid;
    assign bus.out_opcode   = opcode_q;
    assign bus.out_func4    = func4_q;
    assign bus.out_rd_addr  = rd_q;
    assign bus.out_rs1_data = rs1_data;
    assign bus.out_rs2_data = rs2_data;
endmodule

// File: tb/tb_issue_stage_m1.sv
// Directed scenarios plus randomized traffic for issue_stage_m1, checked against a
// transaction-level model of the held instruction.
module tb_issue_stage_m1;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clk_en = 1'b1;
    logic flush = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;

    issue_stage_m1_if #(.XLEN(16), .RA_W(4)) bus ();

    issue_stage_m1 #(.XLEN(16), .RA_W(4)) dut (
        .clk(clk), .rst(rst), .clk_en(clk_en), .flush(flush), .bus(bus.slave)
    );

    always #5 clk = ~clk;

    // Model: is an instruction held, which operands still wait, and their values.
    bit          m_have;
    bit          m_pend [2];
    logic [3:0]  m_addr [2];
    logic [15:0] m_val  [2];
    logic [3:0]  m_op, m_f4, m_rd;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit exp_ov();
        return m_have && !m_pend[0] && !m_pend[1];
    endfunction

    function automatic bit exp_ir();
        return !m_have || (exp_ov() && bus.out_ready);
    endfunction

    task automatic model_reset();
        m_have = 0;
        for (int x = 0; x < 2; x++) begin
            m_pend[x] = 0; m_addr[x] = 0; m_val[x] = 0;
        end
        m_op = 0; m_f4 = 0; m_rd = 0;
    endtask

    task automatic model_clock();
        bit          ov, ir, fwd;
        logic [3:0]  a [2];
        logic [15:0] d [2];
        bit          b [2];
        if (!clk_en) return;
        if (flush) begin
            m_have = 0; m_pend[0] = 0; m_pend[1] = 0;
            return;
        end
        ov = exp_ov();
        ir = exp_ir();
        a[0] = bus.in_rs1_addr; a[1] = bus.in_rs2_addr;
        d[0] = bus.in_rs1_data; d[1] = bus.in_rs2_data;
        b[0] = bus.in_rs1_busy; b[1] = bus.in_rs2_busy;
        if (m_have) begin
            for (int x = 0; x < 2; x++)
                if (m_pend[x] && bus.wb_en && bus.wb_addr == m_addr[x] && m_addr[x] != 0) begin
                    m_val[x] = bus.wb_data; m_pend[x] = 0;
                end
        end
        if (bus.in_valid && ir) begin
            for (int x = 0; x < 2; x++) begin
                fwd       = bus.wb_en && bus.wb_addr == a[x] && a[x] != 0;
                m_addr[x] = a[x];
                m_pend[x] = b[x] && !fwd && a[x] != 0;
                m_val[x]  = fwd ? bus.wb_data : d[x];
            end
            m_op = bus.in_opcode; m_f4 = bus.in_func4; m_rd = bus.in_rd_addr;
            m_have = 1;
        end else if (ov && bus.out_ready) begin
            m_have = 0;
        end
    endtask

    // Called just after a falling edge with inputs already driven.
    task automatic step();
        #1;
        chk("in_ready", bus.in_ready, exp_ir());
        chk("out_valid", bus.out_valid, exp_ov());
        if (exp_ov()) begin
            chk("opcode", bus.out_opcode, m_op);
            chk("func4", bus.out_func4, m_f4);
            chk("rd", bus.out_rd_addr, m_rd);
            chk("rs1_data", bus.out_rs1_data, m_val[0]);
            chk("rs2_data", bus.out_rs2_data, m_val[1]);
        end
        @(posedge clk);
        model_clock();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        clk_en = 1; flush = 0;
        bus.in_valid = 0; bus.out_ready = 1; bus.wb_en = 0;
        bus.in_rs1_busy = 0; bus.in_rs2_busy = 0;
    endtask

    task automatic drive_instr(input logic [3:0] op, input logic [3:0] a1, input logic [15:0] d1,
                               input bit b1, input logic [3:0] a2, input logic [15:0] d2, input bit b2);
        bus.in_valid = 1; bus.in_opcode = op; bus.in_func4 = ~op; bus.in_rd_addr = op + 4'd1;
        bus.in_rs1_addr = a1; bus.in_rs1_data = d1; bus.in_rs1_busy = b1;
        bus.in_rs2_addr = a2; bus.in_rs2_data = d2; bus.in_rs2_busy = b2;
    endtask

    // Asynchronous pulse away from any clock edge.
    task automatic pulse_reset();
        #2 rst = 1;
        #1;
        model_reset();
        chk("rst_ov", bus.out_valid, 0);
        chk("rst_ir", bus.in_ready, 1);
        chk("rst_rs1", bus.out_rs1_data, 0);
        chk("rst_rs2", bus.out_rs2_data, 0);
        chk("rst_op", bus.out_opcode, 0);
        chk("rst_rd", bus.out_rd_addr, 0);
        rst = 0;
        @(negedge clk);
    endtask

    initial begin
        idle_inputs();
        drive_instr(0, 0, 0, 0, 0, 0, 0);
        bus.in_valid = 0; bus.wb_addr = 0; bus.wb_data = 0;
        model_reset();
        repeat (2) @(negedge clk);
        pulse_reset();

        // Two ready operands: issue one cycle after accept.
        drive_instr(4'h1, 4'd3, 16'h1234, 0, 4'd4, 16'h00FF, 0);
        step();
        idle_inputs();
        #1;
        chk("r037_ov", bus.out_valid, 1);
        chk("r037_rs1", bus.out_rs1_data, 16'h1234);
        chk("r037_rs2", bus.out_rs2_data, 16'h00FF);
        chk("r037_ir", bus.in_ready, 1);
        step();

        // Busy rs1 waits for a later writeback; rs2 is register 0.
        drive_instr(4'h2, 4'd5, 16'h0000, 1, 4'd0, 16'h0101, 1);
        step();
        idle_inputs();
        for (int i = 0; i < 3; i++) begin
            chk("r038_wait_ov", bus.out_valid, 0);
            chk("r038_wait_ir", bus.in_ready, 0);
            step();
        end
        bus.wb_en = 1; bus.wb_addr = 4'd5; bus.wb_data = 16'hBEEF;
        step();
        idle_inputs();
        #1;
        chk("r038_ov", bus.out_valid, 1);
        chk("r038_rs1", bus.out_rs1_data, 16'hBEEF);
        chk("r038_rs2", bus.out_rs2_data, 16'h0101);
        step();

        // Both operands forwarded from a same-cycle writeback.
        drive_instr(4'h3, 4'd7, 16'h0000, 1, 4'd7, 16'h0000, 1);
        bus.wb_en = 1; bus.wb_addr = 4'd7; bus.wb_data = 16'hA5A5;
        step();
        idle_inputs();
        #1;
        chk("r039_ov", bus.out_valid, 1);
        chk("r039_rs1", bus.out_rs1_data, 16'hA5A5);
        chk("r039_rs2", bus.out_rs2_data, 16'hA5A5);
        step();

        // Execute back-pressure, then back-to-back accept on release.
        drive_instr(4'hA, 4'd1, 16'h1111, 0, 4'd2, 16'h2222, 0);
        bus.out_ready = 0;
        step();
        bus.in_valid = 0;
        for (int i = 0; i < 4; i++) begin
            chk("r040_ov", bus.out_valid, 1);
            chk("r040_ir", bus.in_ready, 0);
            chk("r040_rs1", bus.out_rs1_data, 16'h1111);
            chk("r040_op", bus.out_opcode, 4'hA);
            step();
        end
        drive_instr(4'h5, 4'd1, 16'h3333, 0, 4'd2, 16'h4444, 0);
        bus.out_ready = 1;
        #1;
        chk("r040_ir_release", bus.in_ready, 1);
        step();
        idle_inputs();
        #1;
        chk("r040_b2b_ov", bus.out_valid, 1);
        chk("r040_b2b_rs1", bus.out_rs1_data, 16'h3333);
        chk("r040_b2b_op", bus.out_opcode, 4'h5);
        step();

        // Flush in WAIT drops the offered instruction; later writeback is ignored.
        drive_instr(4'h6, 4'd9, 16'h0000, 1, 4'd0, 16'h0000, 0);
        step();
        drive_instr(4'h7, 4'd2, 16'h5555, 0, 4'd3, 16'h6666, 0);
        flush = 1;
        step();
        idle_inputs();
        #1;
        chk("r041_ov", bus.out_valid, 0);
        chk("r041_ir", bus.in_ready, 1);
        bus.wb_en = 1; bus.wb_addr = 4'd9; bus.wb_data = 16'h9999;
        step();
        idle_inputs();
        #1;
        chk("r041_late_wb_ov", bus.out_valid, 0);
        step();

        // Writeback under clk_en=0 is not captured; reset discards the waiting entry.
        drive_instr(4'h8, 4'd6, 16'h0000, 1, 4'd0, 16'h0000, 0);
        step();
        idle_inputs();
        clk_en = 0; bus.wb_en = 1; bus.wb_addr = 4'd6; bus.wb_data = 16'h7777;
        step();
        idle_inputs();
        #1;
        chk("r042_noen_ov", bus.out_valid, 0);
        chk("r042_noen_ir", bus.in_ready, 0);
        step();
        chk("r042_still_wait", bus.out_valid, 0);
        pulse_reset();

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            clk_en          = ($urandom_range(0, 9) != 0);
            flush           = ($urandom_range(0, 19) == 0);
            bus.in_valid    = $urandom_range(0, 1);
            bus.in_opcode   = 4'($urandom);
            bus.in_func4    = 4'($urandom);
            bus.in_rd_addr  = 4'($urandom);
            bus.in_rs1_addr = 4'($urandom_range(0, 7));
            bus.in_rs2_addr = 4'($urandom_range(0, 7));
            bus.in_rs1_data = 16'($urandom);
            bus.in_rs2_data = 16'($urandom);
            bus.in_rs1_busy = ($urandom_range(0, 2) == 0);
            bus.in_rs2_busy = ($urandom_range(0, 2) == 0);
            bus.wb_en       = $urandom_range(0, 1);
            bus.wb_addr     = 4'($urandom_range(0, 7));
            bus.wb_data     = 16'($urandom);
            bus.out_ready   = ($urandom_range(0, 3) != 0);
            step();
            if (i == 300) begin
                idle_inputs();
                pulse_reset();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
